// File: rtl/aes_key_schedule_pkg.sv
// Shared definitions for the AES key schedule: key-length codes, Nk/Nr lookup,
// FSM states and the GF(2^8) S-box helpers used by the word-step unit.
package aes_key_schedule_pkg;

  localparam int MAX_WORDS = 60;

  localparam logic [1:0] KL_128  = 2'd0;
  localparam logic [1:0] KL_192  = 2'd1;
  localparam logic [1:0] KL_256  = 2'd2;
  localparam logic [1:0] KL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KL_128:  nk_of = 4'd4;
      KL_192:  nk_of = 4'd6;
      KL_256:  nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KL_128:  nr_of = 4'd10;
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      else      acc = acc;
      x = xtime(x);
    end
    gf_mul = acc;
  endfunction

  // S-box: multiplicative inverse as a^254 (square-and-multiply), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    sbox = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // The core expects byte 0 (word MSB) in the lowest byte lane.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_schedule_word.sv
// Combinational key-expansion step: optional RotWord, SubWord and Rcon injection
// applied to the previous schedule word.
module aes_key_schedule_word
  import aes_key_schedule_pkg::*;
(
  input  logic [31:0] w_in,
  input  logic [7:0]  rcon,
  input  logic        rot_en,
  input  logic        sub_en,
  output logic [31:0] w_out
);

  logic [31:0] sel_s;
  logic [31:0] sub_s;

  assign sel_s = rot_en ? {w_in[23:0], w_in[31:24]} : w_in;
  assign sub_s = sub_word(sel_s);

  // Pick the transform for this position within the Nk-word group.
  always_comb begin
    w_out = w_in;
    if (rot_en) begin
      w_out = sub_s ^ {rcon, 24'h000000};
    end else if (sub_en) begin
      w_out = sub_s;
    end else begin
      w_out = w_in;
    end
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 round-key responder: expands one word per cycle into a 60-word store
// and serves round_key[Addr] combinationally. Optional AES_KS_ZEROIZE_EN adds Key_zeroize.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] Cipher_key,
  input  logic [1:0]   Key_len,
  input  logic         Key_load,
  input  logic [3:0]   Addr,
`ifdef AES_KS_ZEROIZE_EN
  input  logic         Key_zeroize,
`endif
  output logic [128:0] Key,
  output logic [3:0]   Nr,
  output logic         Ks_busy
);

  ks_state_t   state_r;
  logic [31:0] w_r [MAX_WORDS];
  logic [5:0]  i_r;
  logic [2:0]  imod_r;
  logic [7:0]  rcon_r;
  logic [3:0]  nk_r;
  logic [3:0]  nr_r;
  logic        valid_r;
  logic        busy_r;

  logic        zeroize_s;
  logic        load_s;
  logic        wr_en_s;
  logic        last_s;
  logic [3:0]  nk_load_s;
  logic [31:0] prev_s;
  logic [31:0] back_s;
  logic [31:0] t_s;
  logic [31:0] new_word_s;
  logic [31:0] key_word_s [8];
  logic [127:0] key_s;

`ifdef AES_KS_ZEROIZE_EN
  assign zeroize_s = Key_zeroize;
`else
  assign zeroize_s = 1'b0;
`endif

  assign nk_load_s  = nk_of(Key_len);
  assign load_s     = Key_load && (Key_len != KL_RSVD);
  assign wr_en_s    = (state_r == ST_EXPAND) && !load_s && !zeroize_s;
  assign last_s     = (i_r == {nr_r, 2'b11});
  assign prev_s     = w_r[i_r - 6'd1];
  assign back_s     = w_r[i_r - {2'b00, nk_r}];
  assign new_word_s = back_s ^ t_s;

  for (genvar j = 0; j < 8; j++) begin : g_key_word
    assign key_word_s[j] = Cipher_key[255-32*j -: 32];
  end

  aes_key_schedule_word u_word (
    .w_in  (prev_s),
    .rcon  (rcon_r),
    .rot_en(imod_r == 3'd0),
    .sub_en((nk_r == 4'd8) && (imod_r == 3'd4)),
    .w_out (t_s)
  );

  // Expansion FSM, word/round counters and the Rcon register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      i_r     <= 6'd0;
      imod_r  <= 3'd0;
      rcon_r  <= 8'h01;
      nk_r    <= 4'd4;
      nr_r    <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (zeroize_s) begin
      state_r <= ST_IDLE;
      nr_r    <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (load_s) begin
      state_r <= ST_EXPAND;
      i_r     <= {2'b00, nk_load_s};
      imod_r  <= 3'd0;
      rcon_r  <= 8'h01;
      nk_r    <= nk_load_s;
      nr_r    <= nr_of(Key_len);
      valid_r <= 1'b0;
      busy_r  <= 1'b1;
    end else if (state_r == ST_EXPAND) begin
      i_r <= i_r + 6'd1;
      if (imod_r == 3'd0) rcon_r <= xtime(rcon_r);
      if ({1'b0, imod_r} == (nk_r - 4'd1)) imod_r <= 3'd0;
      else                                 imod_r <= imod_r + 3'd1;
      if (last_s) begin
        state_r <= ST_READY;
        valid_r <= 1'b1;
        busy_r  <= 1'b0;
      end
    end
  end

  // Word store: a load writes the first Nk words, expansion writes w[i] once per cycle.
  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        w_r[g] <= 32'h0;
      end else if (zeroize_s) begin
        w_r[g] <= 32'h0;
      end else if (load_s && (6'(g) < {2'b00, nk_load_s})) begin
        w_r[g] <= key_word_s[3'(g % 8)];
      end else if (wr_en_s && (i_r == 6'(g))) begin
        w_r[g] <= new_word_s;
      end
    end
  end

  // Round-key read mux; rounds beyond the stored schedule read as zero.
  always_comb begin
    key_s = 128'h0;
    if (Addr <= nr_r) begin
      for (int j = 0; j < 4; j++) begin
        key_s[32*j +: 32] = byte_swap(w_r[{Addr, 2'(j)}]);
      end
    end else begin
      key_s = 128'h0;
    end
  end

  assign Key     = {valid_r, key_s};
  assign Nr      = nr_r;
  assign Ks_busy = busy_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 key-expansion model plus directed vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] Cipher_key = 256'h0;
  logic [1:0]   Key_len = 2'd0;
  logic         Key_load = 1'b0;
  logic [3:0]   Addr = 4'd0;
`ifdef AES_KS_ZEROIZE_EN
  logic         Key_zeroize = 1'b0;
`endif
  logic [128:0] Key;
  logic [3:0]   Nr;
  logic         Ks_busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R1 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] R2 = 128'h022200010472cc8e3c778c446fa08be9;
  localparam logic [127:0] R3 = 128'h1e636c7044f36d040b8d18e6d19048fe;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .Cipher_key(Cipher_key),
    .Key_len   (Key_len),
    .Key_load  (Key_load),
    .Addr      (Addr),
`ifdef AES_KS_ZEROIZE_EN
    .Key_zeroize(Key_zeroize),
`endif
    .Key       (Key),
    .Nr        (Nr),
    .Ks_busy   (Ks_busy)
  );

  // ---------------- reference model ----------------
  logic [7:0]  sb [256];
  logic [31:0] m_w [60];
  logic        m_valid;
  logic        m_busy;
  logic        m_known;
  logic [3:0]  m_nr;
  int          m_cnt;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      for (int i = 0; i < 8; i++) begin
        s[3'(i)] = inv[3'(i)] ^ inv[3'((i + 4) % 8)] ^ inv[3'((i + 5) % 8)]
                   ^ inv[3'((i + 6) % 8)] ^ inv[3'((i + 7) % 8)] ^ c[3'(i)];
      end
      sb[8'(a)] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic clear_w();
    for (int i = 0; i < 60; i++) m_w[6'(i)] = 32'h0;
  endtask

  // Textbook FIPS-197 KeyExpansion loop.
  task automatic expand_w(input logic [255:0] ck, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nk; i++) m_w[6'(i)] = ck[8'(255 - 32*i) -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = m_w[6'(i - 1)];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      m_w[6'(i)] = m_w[6'(i - nk)] ^ t;
    end
  endtask

  function automatic logic [127:0] mkey(input logic [3:0] a);
    logic [127:0] r = 128'h0;
    logic [31:0]  w;
    if (a <= m_nr) begin
      for (int k = 0; k < 16; k++) begin
        w = m_w[6'(4*int'(a) + k/4)];
        r[7'(8*k) +: 8] = w[5'(31 - 8*(k%4)) -: 8];
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_known <= 1'b1;
      m_nr    <= 4'd0;
      m_cnt   <= 0;
      clear_w();
`ifdef AES_KS_ZEROIZE_EN
    end else if (Key_zeroize) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_known <= 1'b1;
      m_nr    <= 4'd0;
      clear_w();
`endif
    end else if (Key_load && Key_len != 2'd3) begin
      expand_w(Cipher_key, 4 + 2*int'(Key_len), 10 + 2*int'(Key_len));
      m_nr    <= 4'(10 + 2*int'(Key_len));
      m_cnt   <= 4*(11 + 2*int'(Key_len)) - (4 + 2*int'(Key_len));
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
      m_known <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_known <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [128:0] got, input logic [128:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 129'(Key[128]), 129'(m_valid));
      chk("busy",  129'(Ks_busy),  129'(m_busy));
      chk("nr",    129'(Nr),       129'(m_nr));
      if (m_known) chk("key", 129'(Key[127:0]), 129'(mkey(Addr)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [255:0] k, input logic [1:0] len);
    Cipher_key = k;
    Key_len    = len;
    Key_load   = 1'b1;
    @(posedge clk);
    #1 Key_load = 1'b0;
  endtask

  task automatic wait_valid(input int want, input string name);
    int n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      Addr = 4'(n);
      if (Key[128]) break;
    end
    chk(name, 129'(n), 129'(want));
  endtask

  task automatic sweep_addr();
    for (int a = 0; a < 16; a++) begin
      Addr = 4'(a);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    build_sbox();
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_key", Key, 129'h0);
    chk("reset_nr", 129'(Nr), 129'h0);
    chk("reset_busy", 129'(Ks_busy), 129'h0);

    // AES-128
    do_load(K1, 2'd0);
    wait_valid(40, "lat128");
    chk("nr128", 129'(Nr), 129'd10);
    Addr = 4'd10;
    #1 chk("a1_rk10", 129'(Key[127:0]), 129'(R1));
    Addr = 4'd11;
    #1 chk("a1_addr_gt_nr", Key, {1'b1, 128'h0});
    sweep_addr();

    // AES-192
    do_load(K2, 2'd1);
    wait_valid(46, "lat192");
    Addr = 4'd12;
    #1 chk("a2_rk12", 129'(Key[127:0]), 129'(R2));
    chk("nr192", 129'(Nr), 129'd12);
    sweep_addr();

    // AES-256
    do_load(K3, 2'd2);
    wait_valid(52, "lat256");
    Addr = 4'd14;
    #1 chk("a3_rk14", 129'(Key[127:0]), 129'(R3));
    sweep_addr();

    // Reserved length is ignored
    do_load(K1, 2'd3);
    repeat (3) @(posedge clk);
    #1 Addr = 4'd14;
    #1 chk("rsvd_keeps", Key, {1'b1, R3});
    chk("rsvd_nr", 129'(Nr), 129'd14);

    // Restart mid-expansion
    do_load(K1, 2'd0);
    repeat (20) @(posedge clk);
    #1 do_load(K3, 2'd2);
    wait_valid(52, "lat_restart");
    Addr = 4'd14;
    #1 chk("restart_rk14", 129'(Key[127:0]), 129'(R3));

    // Reset during expansion
    do_load(K2, 2'd1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    Addr = 4'd0;
    #1 chk("rst_mid_key", Key, 129'h0);
    chk("rst_mid_nr", 129'(Nr), 129'h0);
    chk("rst_mid_busy", 129'(Ks_busy), 129'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    sweep_addr();

`ifdef AES_KS_ZEROIZE_EN
    do_load(K1, 2'd0);
    wait_valid(40, "lat_zz");
    Key_zeroize = 1'b1;
    Key_load    = 1'b1;
    @(posedge clk);
    #1 Key_zeroize = 1'b0;
    Key_load = 1'b0;
    for (int a = 0; a < 16; a++) begin
      Addr = 4'(a);
      #1 chk("zeroize_key", Key, 129'h0);
    end
    chk("zeroize_busy", 129'(Ks_busy), 129'h0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
